// File: rtl/handshake_const_checker.sv
// Consumes tokens, compares each against EXPECTED, reports pass/mismatch count/first bad per window.
// Compare is 1 cycle after acceptance; input stalls while the result token waits for result_ready.
module handshake_const_checker #(
   parameter int                    DATA_WIDTH  = 18,
   parameter logic [DATA_WIDTH-1:0] EXPECTED    = 18'b110011111100100010,
   parameter int                    TOKEN_COUNT = 16,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  result_pass,
   output logic [CNT_WIDTH-1:0]  result_mismatches,
   output logic [DATA_WIDTH-1:0] result_first_bad,
   output logic                  result_valid,
   input  logic                  result_ready
);

   typedef enum logic {RUN, REPORT} state_t;

   localparam logic [CNT_WIDTH-1:0] TC      = CNT_WIDTH'(TOKEN_COUNT);
   localparam logic [CNT_WIDTH-1:0] TC_LAST = CNT_WIDTH'(TOKEN_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  accepted;
   logic [CNT_WIDTH-1:0]  compared;
   logic [CNT_WIDTH-1:0]  mismatches;
   logic                  stage_valid;
   logic [DATA_WIDTH-1:0] stage_data;
   logic [DATA_WIDTH-1:0] first_bad;
   logic                  bad_seen;
   logic                  take;
   logic                  last_cmp;
   logic                  release_res;

   // rst gates ready so no transfer can be advertised while reset is held
   assign ins_ready   = rst && (state == RUN) && (accepted < TC);
   assign take        = ins_valid && ins_ready;
   assign last_cmp    = stage_valid && (compared == TC_LAST);
   assign release_res = (state == REPORT) && result_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (last_cmp)     state_nxt = REPORT;
         REPORT:  if (result_ready) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         accepted    <= '0;
         compared    <= '0;
         mismatches  <= '0;
         stage_valid <= 1'b0;
         stage_data  <= '0;
         first_bad   <= '0;
         bad_seen    <= 1'b0;
      end else begin
         stage_valid <= take;
         if (take) begin
            stage_data <= ins;
         end
         if (release_res) begin
            accepted   <= '0;
            compared   <= '0;
            mismatches <= '0;
            first_bad  <= '0;
            bad_seen   <= 1'b0;
         end else begin
            if (take) begin
               accepted <= accepted + ONE;
            end
            if (stage_valid) begin
               compared <= compared + ONE;
               if (stage_data != EXPECTED) begin
                  if (mismatches != '1) begin
                     mismatches <= mismatches + ONE;
                  end
                  if (!bad_seen) begin
                     first_bad <= stage_data;
                     bad_seen  <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign result_valid      = (state == REPORT);
   assign result_pass       = (mismatches == '0);
   assign result_mismatches = mismatches;
   assign result_first_bad  = first_bad;

endmodule

// File: tb/tb_handshake_const_checker.sv
// Randomized bench for handshake_const_checker: a window-level model predicts every output each cycle.
module tb_handshake_const_checker;

   localparam int DW = 18;
   localparam int CW = 16;
   localparam logic [DW-1:0] EXP = 18'b110011111100100010;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] ins       [2];
   logic          ins_valid [2];
   logic          ins_ready [2];
   logic          r_pass    [2];
   logic [CW-1:0] r_mism    [2];
   logic [DW-1:0] r_first   [2];
   logic          r_valid   [2];
   logic          r_ready   [2];

   always #5 clk = ~clk;

   handshake_const_checker #(.DATA_WIDTH(DW), .EXPECTED(EXP), .TOKEN_COUNT(16), .CNT_WIDTH(CW)) u0 (
      .clk(clk), .rst(rst), .ins(ins[0]), .ins_valid(ins_valid[0]), .ins_ready(ins_ready[0]),
      .result_pass(r_pass[0]), .result_mismatches(r_mism[0]), .result_first_bad(r_first[0]),
      .result_valid(r_valid[0]), .result_ready(r_ready[0]));

   handshake_const_checker #(.DATA_WIDTH(DW), .EXPECTED(EXP), .TOKEN_COUNT(1), .CNT_WIDTH(CW)) u1 (
      .clk(clk), .rst(rst), .ins(ins[1]), .ins_valid(ins_valid[1]), .ins_ready(ins_ready[1]),
      .result_pass(r_pass[1]), .result_mismatches(r_mism[1]), .result_first_bad(r_first[1]),
      .result_valid(r_valid[1]), .result_ready(r_ready[1]));

   // Window-level model: tokens taken so far, bad count, first bad value, report phase
   int            n_acc  [2];
   int            n_bad  [2];
   logic [DW-1:0] fbad   [2];
   bit            gap    [2];
   bit            in_rep [2];

   function automatic int tc(input int c);
      return (c == 0) ? 16 : 1;
   endfunction

   function automatic bit exp_rdy(input int c);
      return rst && !in_rep[c] && !gap[c] && (n_acc[c] < tc(c));
   endfunction

   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (!rst) begin
            n_acc[c] = 0; n_bad[c] = 0; fbad[c] = '0; gap[c] = 0; in_rep[c] = 0;
         end else if (in_rep[c]) begin
            if (r_ready[c]) begin
               in_rep[c] = 0; n_acc[c] = 0; n_bad[c] = 0; fbad[c] = '0;
            end
         end else if (gap[c]) begin
            gap[c] = 0; in_rep[c] = 1;
         end else if (n_acc[c] < tc(c) && ins_valid[c]) begin
            n_acc[c]++;
            if (ins[c] != EXP) begin
               if (n_bad[c] == 0) fbad[c] = ins[c];
               if (n_bad[c] < 65535) n_bad[c]++;
            end
            if (n_acc[c] == tc(c)) gap[c] = 1;
         end
      end
   end

   int            errors = 0;
   int            checks = 0;
   int            obs_cnt   [2];
   logic          obs_pass  [2];
   logic [CW-1:0] obs_mism  [2];
   logic [DW-1:0] obs_first [2];
   logic          pin_vld = 1'b0;
   int            pin_ch, pin_cnt;
   logic          pin_pass;
   logic [CW-1:0] pin_mism;
   logic [DW-1:0] pin_first;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("ins_ready%0d", c), 32'(ins_ready[c]), 32'(exp_rdy(c)));
         chk($sformatf("result_valid%0d", c), 32'(r_valid[c]), 32'(rst && in_rep[c]));
         if (rst && in_rep[c]) begin
            chk($sformatf("result_pass%0d", c), 32'(r_pass[c]), 32'(n_bad[c] == 0));
            chk($sformatf("result_mismatches%0d", c), 32'(r_mism[c]), 32'(n_bad[c]));
            chk($sformatf("result_first_bad%0d", c), 32'(r_first[c]), 32'(fbad[c]));
         end
         if (r_valid[c] && r_ready[c]) begin
            obs_cnt[c]++;
            obs_pass[c] = r_pass[c]; obs_mism[c] = r_mism[c]; obs_first[c] = r_first[c];
         end
      end
      if (pin_vld) begin
         chk("pin_result_count", 32'(obs_cnt[pin_ch]), 32'(pin_cnt));
         chk("pin_pass", 32'(obs_pass[pin_ch]), 32'(pin_pass));
         chk("pin_mismatches", 32'(obs_mism[pin_ch]), 32'(pin_mism));
         chk("pin_first_bad", 32'(obs_first[pin_ch]), 32'(pin_first));
         obs_cnt[pin_ch] = 0;
      end
   end

   logic [DW-1:0] tx_q[$];

   task automatic push_window(input int n, input int bad_a, input int bad_b, input logic [DW-1:0] va,
                              input logic [DW-1:0] vb);
      for (int i = 0; i < n; i++)
         tx_q.push_back((i == bad_a) ? va : (i == bad_b) ? vb : EXP);
   endtask

   task automatic run0(input int pct, input int hold, input bit rr_rand);
      int tail  = 0;
      int guard = 0;
      bit pend, rv;
      while ((tx_q.size() > 0 || tail < 8) && guard < 3000) begin
         @(negedge clk);
         pend = ins_valid[0] && ins_ready[0];
         rv   = r_valid[0];
         @(posedge clk); #2;
         if (pend) void'(tx_q.pop_front());
         if (tx_q.size() > 0 && $urandom_range(99) < pct) begin
            ins_valid[0] = 1'b1; ins[0] = tx_q[0];
         end else begin
            ins_valid[0] = 1'b0; ins[0] = DW'($urandom);
         end
         if (hold > 0) begin
            r_ready[0] = 1'b0;
            if (rv) hold--;
         end else begin
            r_ready[0] = rr_rand ? 1'($urandom_range(1)) : 1'b1;
         end
         tail = (tx_q.size() == 0 && !rv) ? tail + 1 : 0;
         guard++;
      end
      ins_valid[0] = 1'b0;
      r_ready[0]   = 1'b1;
   endtask

   task automatic pin(input int ch, input int cnt, input logic p, input logic [CW-1:0] m, input logic [DW-1:0] f);
      @(posedge clk); #2;
      pin_ch = ch; pin_cnt = cnt; pin_pass = p; pin_mism = m; pin_first = f; pin_vld = 1'b1;
      @(posedge clk); #2;
      pin_vld = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < 2; c++) begin
         ins[c] = '0; ins_valid[c] = 1'b0; r_ready[c] = 1'b1; obs_cnt[c] = 0;
         obs_pass[c] = 1'b0; obs_mism[c] = '0; obs_first[c] = '0;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // all good, back-to-back
      push_window(16, -1, -1, '0, '0);
      run0(100, 0, 0);
      pin(0, 1, 1'b1, 16'd0, 18'h0);

      // tokens #3 and #9 bad
      push_window(16, 2, 8, 18'h00001, 18'h3FFFF);
      run0(100, 0, 0);
      pin(0, 1, 1'b0, 16'd2, 18'h00001);

      // 50% valid gaps
      push_window(16, -1, -1, '0, '0);
      run0(50, 0, 0);
      pin(0, 1, 1'b1, 16'd0, 18'h0);

      // result held 10 cycles with ins_valid high, then a window with 4 bad
      push_window(16, -1, -1, '0, '0);
      for (int i = 0; i < 16; i++)
         tx_q.push_back((i == 1) ? 18'h0AAAA : (i == 5) ? 18'h3FFFF : (i == 10) ? 18'h0 :
                        (i == 15) ? (EXP ^ 18'h1) : EXP);
      run0(100, 10, 0);
      pin(0, 2, 1'b0, 16'd4, 18'h0AAAA);

      // reset mid-window discards the partial count
      push_window(7, 0, -1, 18'h00055, '0);
      run0(100, 0, 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      push_window(16, -1, -1, '0, '0);
      run0(100, 0, 0);
      pin(0, 1, 1'b1, 16'd0, 18'h0);

      // single-token window
      @(posedge clk); #2;
      ins[1] = 18'h12345; ins_valid[1] = 1'b1;
      @(posedge clk); #2;
      ins_valid[1] = 1'b0;
      repeat (5) @(posedge clk);
      pin(1, 1, 1'b0, 16'd1, 18'h12345);

      // random data, gaps and result backpressure
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < 16; i++)
            tx_q.push_back(($urandom_range(3) == 0) ? DW'($urandom) : EXP);
      run0(60, 0, 1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
